phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Replaces the free-running 12-phase cpu_clock with a state-driven sequencer.
//  Emits one-hot phase enables in place of the clock_1..clock_12 strobes to fetch, decode, selector, alu,
//  alu_result_selector and the register files (eip/ebp/esp/eax/ebx/stack).
//  Unused operand slots are skipped, so an instruction takes 5 + 2*(ops-1) cycles instead of a fixed 12.
//  Waits on instruction-memory ready, supports halt, and keeps a retired-instruction count.
// PARAMETERS
//  MAX_OPS        3   operand slots per instruction (1..3); num_of_ope clamps to this
//  FETCH_WAIT_MAX 15  FETCH cycles without mem_ready before timeout
//  CNT_W          16  width of retired_cnt
// PORTS
//  clk            in   1      system clock; all state changes on rising edge
//  reset          in   1      asynchronous, active-low; 0 = in reset
//  num_of_ope     in   4      operand count from decode, valid from cycle after DECODE
//  mem_ready      in   1      fetch data valid this cycle
//  halt_req       in   1      level; stop after current instruction retires
//  step           in   1      single-step pulse (only with SEQ_SINGLE_STEP_EN)
//  phase_en       out  12     one-hot; bit k-1 replaces clock_k
//  op_idx         out  2      active operand slot 1..3, 0 outside SEL/EXEC
//  instr_done     out  1      1-cycle pulse in EIPUPD
//  busy           out  1      1 in every state except IDLE/HALT/PAUSE
//  halted         out  1      1 in HALT
//  fetch_timeout  out  1      sticky; set on fetch timeout, cleared only by reset
//  retired_cnt    out  CNT_W  instructions retired, wraps to 0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; wait counter and latched op count cleared.
//    Mid-instruction reset aborts immediately: phase_en=0 in the same cycle, no partial retire.
//  IDLE: 1 cycle after reset release, phase_en=0 -> FETCH.
//  FETCH: phase_en[0]=1, held until mem_ready=1 -> DECODE.
//    Wait counter increments each cycle with mem_ready=0.
//    Counter reaching FETCH_WAIT_MAX -> fetch_timeout=1, go to HALT.
//  DECODE: phase_en[1], 1 cycle -> SEL1.
//  SELi (i=1..n): phase_en[2i]; op_idx=i; 1 cycle -> EXECi.
//    At end of SEL1, n is latched from num_of_ope: 0 -> 1, >MAX_OPS -> MAX_OPS.
//  EXECi: phase_en[2i+1]; op_idx=i; 1 cycle.
//    i<n -> SEL(i+1); i==n -> EIPUPD.
//  EIPUPD: phase_en[11]; instr_done=1; retired_cnt+=1 (mod 2^CNT_W).
//    Next state: halt_req=1 -> HALT; otherwise FETCH.
//  HALT: phase_en=0; halted=1; exit only via reset.
//  phase_en[10:8] (clock_9..11) are reserved and held 0.
//  phase_en is exactly one-hot or all-zero at all times.
//  halt_req is sampled only in EIPUPD, so in-flight instructions always complete.
//  Latency with mem_ready=1: 1 op = 5 cycles, 2 ops = 7, 3 ops = 9 (FETCH to EIPUPD inclusive).
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined:
//    Adds the step port and a PAUSE state entered after every EIPUPD (halt_req still wins -> HALT).
//    PAUSE: phase_en=0, busy=0; a cycle with step=1 -> FETCH; halt_req=1 in PAUSE -> HALT.
//  SEQ_SINGLE_STEP_EN undefined:
//    No step port, no PAUSE; EIPUPD goes directly to FETCH/HALT.
// STRUCTURE
//  cpu_defs.vh (shared include, acts as package):
//    state encodings; PH_FETCH..PH_EIP bit indices; OPS_W.
//    Also used by selector/alu/alu_result_selector once they migrate to phase_en.
//  Sub-module fetch_wait_timer: counter, clear on FETCH entry, timeout flag.
//  All other logic stays in this file (state register, next-state logic, op latch, retire counter).
// TESTING
//  1. mem_ready=1, num_of_ope=1 -> phase_en 0x001,0x002,0x004,0x008,0x800; instr_done in cycle 5; retired_cnt=1.
//  2. num_of_ope=3 -> 0x001,0x002,0x004,0x008,0x010,0x020,0x040,0x080,0x800; op_idx 1,1,2,2,3,3; bits 10:8 never set.
//  3. num_of_ope=0 runs as 1 op; num_of_ope=9 runs as 3 ops (9 cycles).
//  4. mem_ready low 4 cycles -> FETCH held 5 cycles, then normal; mem_ready low 15 cycles -> fetch_timeout=1, halted=1.
//  5. halt_req raised in EXEC2 of 3-op instruction -> instruction completes, retired_cnt+1, then halted=1, phase_en=0.
//  6. reset=0 asserted in EXEC1 -> phase_en=0 immediately, retired_cnt=0; release -> IDLE, FETCH.
//     With SEQ_SINGLE_STEP_EN: stays in PAUSE until a step pulse.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared state encodings, phase bit indices and op-count helper
package phase_sequencer_pkg;

  localparam int OPS_W     = 2;
  localparam int PH_W      = 12;
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_SEL1   = 2;
  localparam int PH_EXEC1  = 3;
  localparam int PH_EIP    = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_SEL    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_EIPUPD = 3'd5,
    ST_HALT   = 3'd6,
    ST_PAUSE  = 3'd7
  } seq_state_t;

  // Zero operands still needs one SEL/EXEC pass; oversize counts saturate.
  function automatic logic [OPS_W-1:0] clamp_ops(input logic [3:0] n,
                                                 input logic [OPS_W-1:0] max_ops);
    logic [OPS_W-1:0] r;
    if (n == 4'd0)
      r = OPS_W'(1);
    else if (n > {2'b00, max_ops})
      r = max_ops;
    else
      r = n[OPS_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - sequencer control/status bundle (step exists only with SEQ_SINGLE_STEP_EN)
interface phase_sequencer_if #(parameter int CNT_W = 16) ();

  logic [3:0]       num_of_ope;
  logic             mem_ready;
  logic             halt_req;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
`endif
  logic [11:0]      phase_en;
  logic [1:0]       op_idx;
  logic             instr_done;
  logic             busy;
  logic             halted;
  logic             fetch_timeout;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    input  num_of_ope, mem_ready, halt_req,
    output phase_en, op_idx, instr_done, busy, halted, fetch_timeout, retired_cnt
  );

  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    output num_of_ope, mem_ready, halt_req,
    input  phase_en, op_idx, instr_done, busy, halted, fetch_timeout, retired_cnt
  );

endinterface

// File: rtl/phase_sequencer_fetch_wait_timer.sv
// rtl/phase_sequencer_fetch_wait_timer.sv - counts FETCH cycles without mem_ready, sticky timeout flag
module phase_sequencer_fetch_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic in_fetch,
  input  logic mem_ready,
  output logic expire,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  // Fires on the WAIT_MAX-th consecutive starved FETCH cycle.
  assign expire = in_fetch && !mem_ready && (cnt == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (!in_fetch)
        cnt <= '0;
      else if (!mem_ready && cnt != CW'(WAIT_MAX))
        cnt <= cnt + CW'(1);
      if (expire)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - state-driven one-hot phase sequencer; SEQ_SINGLE_STEP_EN adds step/PAUSE
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MAX_OPS        = 3,
  parameter int FETCH_WAIT_MAX = 15,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.master bus
);

  seq_state_t       state, state_nx;
  logic [OPS_W-1:0] cur_op, cur_op_nx;
  logic [OPS_W-1:0] n_ops;
  logic [CNT_W-1:0] retired;
  logic [PH_W-1:0]  phase_en;
  logic [1:0]       op_idx;
  logic             instr_done, busy, halted;
  logic             fetch_expire, fetch_timeout;
  logic [3:0]       sel_bit;

  phase_sequencer_fetch_wait_timer #(
    .WAIT_MAX (FETCH_WAIT_MAX)
  ) u_fetch_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .in_fetch  (state == ST_FETCH),
    .mem_ready (bus.mem_ready),
    .expire    (fetch_expire),
    .timeout   (fetch_timeout)
  );

  // SELi sits on bit 2i, EXECi on bit 2i+1.
  assign sel_bit = 4'(PH_SEL1) + {1'b0, cur_op - 2'd1, 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cur_op <= '0;
    end else begin
      state  <= state_nx;
      cur_op <= cur_op_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_ops   <= '0;
      retired <= '0;
    end else begin
      if (state == ST_SEL && cur_op == OPS_W'(1))
        n_ops <= clamp_ops(bus.num_of_ope, OPS_W'(MAX_OPS));
      if (state == ST_EIPUPD)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    cur_op_nx  = cur_op;
    phase_en   = '0;
    op_idx     = '0;
    instr_done = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        phase_en[PH_FETCH] = 1'b1;
        if (bus.mem_ready)
          state_nx = ST_DECODE;
        else if (fetch_expire)
          state_nx = ST_HALT;
      end
      ST_DECODE: begin
        phase_en[PH_DECODE] = 1'b1;
        cur_op_nx           = OPS_W'(1);
        state_nx            = ST_SEL;
      end
      ST_SEL: begin
        phase_en = PH_W'(1) << sel_bit;
        op_idx   = cur_op;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        phase_en = PH_W'(1) << (sel_bit + 4'd1);
        op_idx   = cur_op;
        if (cur_op < n_ops) begin
          cur_op_nx = cur_op + OPS_W'(1);
          state_nx  = ST_SEL;
        end else begin
          cur_op_nx = '0;
          state_nx  = ST_EIPUPD;
        end
      end
      ST_EIPUPD: begin
        phase_en[PH_EIP] = 1'b1;
        instr_done       = 1'b1;
        if (bus.halt_req)
          state_nx = ST_HALT;
        else
`ifdef SEQ_SINGLE_STEP_EN
          state_nx = ST_PAUSE;
`else
          state_nx = ST_FETCH;
`endif
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      ST_PAUSE: begin
        busy = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        if (bus.halt_req)
          state_nx = ST_HALT;
        else if (bus.step)
          state_nx = ST_FETCH;
`else
        state_nx = ST_FETCH;
`endif
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.phase_en      = phase_en;
  assign bus.op_idx        = op_idx;
  assign bus.instr_done    = instr_done;
  assign bus.busy          = busy;
  assign bus.halted        = halted;
  assign bus.fetch_timeout = fetch_timeout;
  assign bus.retired_cnt   = retired;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
module tb_phase_sequencer;

  typedef struct {
    logic [11:0] ph;
    logic [1:0]  op;
    logic        done;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  ent_t mon_e;

  phase_sequencer_if #(.CNT_W(16)) bus ();

  phase_sequencer #(
    .MAX_OPS        (3),
    .FETCH_WAIT_MAX (15),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] ph, input logic [1:0] op, input logic done);
    ent_t e;
    e.ph = ph; e.op = op; e.done = done;
    exp_q.push_back(e);
  endtask

  // Expected phase trace of one instruction: FETCH x(waits+1), DECODE, SEL/EXEC per op, EIPUPD.
  task automatic push_instr(input int n_eff, input int waits);
    for (int w = 0; w <= waits; w++) push(12'h001, 2'd0, 1'b0);
    push(12'h002, 2'd0, 1'b0);
    for (int i = 1; i <= n_eff; i++) begin
      push(12'h001 << (2 * i), 2'(i), 1'b0);
      push(12'h001 << (2 * i + 1), 2'(i), 1'b0);
    end
    push(12'h800, 2'd0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.phase_en != 12'h000) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_phase actual=0x%0h required=none", bus.phase_en);
      end else begin
        mon_e = exp_q.pop_front();
        chk("phase_en", 32'(bus.phase_en), 32'(mon_e.ph));
        chk("op_idx", 32'(bus.op_idx), 32'(mon_e.op));
        chk("instr_done", 32'(bus.instr_done), 32'(mon_e.done));
        chk("busy", 32'(bus.busy), 32'd1);
        chk("reserved_10_8", 32'(bus.phase_en[10:8]), 32'd0);
      end
    end
  end

  task automatic wait_phase(input logic [11:0] target, input string name);
    int k = 0;
    while (bus.phase_en != target && k < 60) begin
      tick();
      k++;
    end
    chk({"reach_", name}, 32'(bus.phase_en), 32'(target));
  endtask

  task automatic start_test(input logic [3:0] nope, input logic hreq);
    reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    mem_ready_set(1'b0);
    bus.num_of_ope = nope;
    bus.halt_req   = hreq;
    reset = 1'b1;
  endtask

  task automatic mem_ready_set(input logic v);
    bus.mem_ready = v;
  endtask

  task automatic fetch_then_ready(input int waits);
    wait_phase(12'h001, "fetch");
    repeat (waits) tick();
    mem_ready_set(1'b1);
  endtask

  task automatic finish_check(input string name, input int exp_ret, input logic exp_to);
    int k = 0;
    while (bus.halted !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk({name, "_halted"}, 32'(bus.halted), 32'd1);
    chk({name, "_phase_idle"}, 32'(bus.phase_en), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_retired"}, 32'(bus.retired_cnt), 32'(exp_ret));
    chk({name, "_timeout"}, 32'(bus.fetch_timeout), 32'(exp_to));
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.num_of_ope = 4'd1;
    bus.mem_ready  = 1'b0;
    bus.halt_req   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step       = 1'b1;
`endif
    tick();
    tick();
    chk("reset_outputs",
        {8'd0, bus.phase_en, bus.op_idx, bus.instr_done, bus.busy, bus.halted, bus.fetch_timeout},
        32'd0);
    chk("reset_retired", 32'(bus.retired_cnt), 32'd0);

    // 1 op, no wait: 0x001,0x002,0x004,0x008,0x800
    start_test(4'd1, 1'b1);
    push_instr(1, 0);
    fetch_then_ready(0);
    finish_check("one_op", 1, 1'b0);

    // 3 ops
    start_test(4'd3, 1'b1);
    push_instr(3, 0);
    fetch_then_ready(0);
    finish_check("three_op", 1, 1'b0);

    // num_of_ope=0 clamps up to 1, 9 clamps down to 3
    start_test(4'd0, 1'b1);
    push_instr(1, 0);
    fetch_then_ready(0);
    finish_check("zero_op", 1, 1'b0);

    start_test(4'd9, 1'b1);
    push_instr(3, 0);
    fetch_then_ready(0);
    finish_check("nine_op", 1, 1'b0);

    // mem_ready low 4 cycles: FETCH held 5 cycles
    start_test(4'd2, 1'b1);
    push_instr(2, 4);
    fetch_then_ready(4);
    finish_check("wait4", 1, 1'b0);

    // 14 starved cycles is one short of timeout
    start_test(4'd1, 1'b1);
    push_instr(1, 14);
    fetch_then_ready(14);
    finish_check("wait14", 1, 1'b0);

    // 15 starved cycles: timeout, halt
    start_test(4'd1, 1'b0);
    for (int w = 0; w < 15; w++) push(12'h001, 2'd0, 1'b0);
    finish_check("timeout", 0, 1'b1);

    // halt_req raised in EXEC2 of a 3-op instruction
    start_test(4'd3, 1'b0);
    push_instr(3, 0);
    fetch_then_ready(0);
    wait_phase(12'h020, "exec2");
    bus.halt_req = 1'b1;
    finish_check("halt_exec2", 1, 1'b0);

    // back-to-back: 1 op then 2 ops
    start_test(4'd1, 1'b0);
    push_instr(1, 0);
    push_instr(2, 0);
    fetch_then_ready(0);
    wait_phase(12'h800, "eip_first");
    bus.num_of_ope = 4'd2;
    tick();
    bus.halt_req = 1'b1;
    finish_check("back2back", 2, 1'b0);

    // reset in EXEC1 of the second instruction
    start_test(4'd1, 1'b0);
    push_instr(1, 0);
    push(12'h001, 2'd0, 1'b0);
    push(12'h002, 2'd0, 1'b0);
    push(12'h004, 2'd1, 1'b0);
    push(12'h008, 2'd1, 1'b0);
    fetch_then_ready(0);
    wait_phase(12'h800, "eip_pre_reset");
    bus.num_of_ope = 4'd2;
    wait_phase(12'h008, "exec1_pre_reset");
    chk("retired_pre_reset", 32'(bus.retired_cnt), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_phase", 32'(bus.phase_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_op_idx", 32'(bus.op_idx), 32'd0);
    chk("abort_retired", 32'(bus.retired_cnt), 32'd0);
    chk("abort_queue_left", 32'(exp_q.size()), 32'd0);
    bus.halt_req   = 1'b1;
    bus.num_of_ope = 4'd1;
    tick();
    push_instr(1, 0);
    reset = 1'b1;
    #1;
    chk("release_idle", 32'(bus.phase_en), 32'd0);
    tick();
    chk("release_fetch", 32'(bus.phase_en), 32'h001);
    finish_check("after_reset", 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
